// File: rtl/btn_enable_ctrl.sv
// Button front end for the LED blinker: synchronise, debounce, classify press
// length; a short press toggles enable, a long press forces it off.
module btn_enable_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int BTN_ACTIVE_LOW    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       enable,
  output logic       press_pulse,
  output logic       long_pulse,
  output logic [1:0] state
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic              POL_INV  = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  logic              s1_q, s1_d, s2_q, s2_d;
  logic              btn_db_q, btn_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  state_e            state_q, state_d;
  logic              enable_q, enable_d;
  logic              press_pulse_q, press_pulse_d;
  logic              long_pulse_q, long_pulse_d;

  // Next-state logic: synchroniser, debounce filter and press classifier.
  always_comb begin
    // Synchroniser stores the normalised level: 1 means pressed.
    s1_d          = btn_raw ^ POL_INV;
    s2_d          = s1_q;
    btn_db_d      = btn_db_q;
    db_cnt_d      = db_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    state_d       = state_q;
    enable_d      = enable_q;
    press_pulse_d = 1'b0;
    long_pulse_d  = 1'b0;

    if (s2_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      btn_db_d = ~btn_db_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end

    case (state_q)
      RELEASED: begin
        if (btn_db_q) begin
          state_d    = HELD;
          hold_cnt_d = '0;
        end else begin
          state_d = RELEASED;
        end
      end
      HELD: begin
        // Release is tested first so it wins over the long-press threshold.
        if (!btn_db_q) begin
          enable_d      = ~enable_q;
          press_pulse_d = 1'b1;
          state_d       = RELEASED;
        end else if (hold_cnt_q == HOLD_MAX) begin
          enable_d     = 1'b0;
          long_pulse_d = 1'b1;
          state_d      = LONG_HELD;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      LONG_HELD: begin
        if (!btn_db_q) begin
          state_d = RELEASED;
        end else begin
          state_d = LONG_HELD;
        end
      end
      default: begin
        state_d = RELEASED;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      btn_db_q      <= 1'b0;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      state_q       <= RELEASED;
      enable_q      <= 1'b0;
      press_pulse_q <= 1'b0;
      long_pulse_q  <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      btn_db_q      <= btn_db_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      state_q       <= state_d;
      enable_q      <= enable_d;
      press_pulse_q <= press_pulse_d;
      long_pulse_q  <= long_pulse_d;
    end
  end

  assign enable      = enable_q;
  assign press_pulse = press_pulse_q;
  assign long_pulse  = long_pulse_q;
  assign state       = state_q;

endmodule

// File: tb/tb_btn_enable_ctrl.sv
// Bench for btn_enable_ctrl: directed button waveforms push expected pulse
// events into a queue; a monitor process checks each pulse as it appears.
module tb_btn_enable_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       enable;
  logic       press_pulse;
  logic       long_pulse;
  logic [1:0] state;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic is_long;
    logic en;
    int   at;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  btn_enable_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(16),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .enable(enable),
    .press_pulse(press_pulse),
    .long_pulse(long_pulse),
    .state(state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait n rising edges, then move 2 time units past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_ev(input logic is_long, input logic en, input int dly);
    ev_t e;
    e.is_long = is_long;
    e.en      = en;
    e.at      = cyc + dly;
    exp_q.push_back(e);
  endtask

  // Press for 'low' cycles; the pulse lands 7 edges after the raw release.
  task automatic short_press(input int low, input logic en_after);
    btn_raw = 1'b0;
    tick(low);
    btn_raw = 1'b1;
    expect_ev(1'b0, en_after, 7);
    tick(7);
    check("press_pulse", press_pulse, 1);
    check("enable_after_press", enable, en_after);
    check("state_after_press", state, 0);
    tick(1);
    check("press_width", press_pulse, 0);
    tick(12);
  endtask

  initial begin
    rst     = 1'b0;
    btn_raw = 1'b1;

    fork
      begin : monitor
        ev_t  e;
        logic prev_en    = 1'b0;
        logic prev_pulse = 1'b0;
        forever begin
          @(negedge clk);
          if (rst) begin
            check("pulse_exclusive", press_pulse & long_pulse, 0);
            if (press_pulse | long_pulse) begin
              check("pulse_spacing", prev_pulse, 0);
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: press=%0d long=%0d at cycle %0d, none expected",
                         press_pulse, long_pulse, cyc);
              end else begin
                e = exp_q.pop_front();
                check("pulse_kind_long", long_pulse, e.is_long);
                check("pulse_cycle", cyc, e.at);
                check("pulse_enable", enable, e.en);
              end
            end else begin
              if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: no pulse by cycle %0d, expected long=%0d at cycle %0d",
                         cyc, e.is_long, e.at);
              end
              check("enable_stable", enable, prev_en);
            end
          end
          prev_en    = enable;
          prev_pulse = press_pulse | long_pulse;
        end
      end
    join_none

    // Reset values and idle behaviour.
    tick(3);
    check("rst_enable", enable, 0);
    check("rst_press", press_pulse, 0);
    check("rst_long", long_pulse, 0);
    check("rst_state", state, 0);
    rst = 1'b1;
    tick(20);
    check("idle_enable", enable, 0);
    check("idle_state", state, 0);

    // Two short presses: enable 0 -> 1 -> 0.
    short_press(10, 1'b1);
    short_press(10, 1'b0);

    // Glitches shorter than the debounce window never reach btn_db.
    for (int k = 0; k < 3; k++) begin
      btn_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        check("glitch_db_low", dut.btn_db_q, 0);
      end
      btn_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        check("glitch_db_high", dut.btn_db_q, 0);
      end
    end
    tick(6);
    check("glitch_db_final", dut.btn_db_q, 0);
    check("glitch_enable", enable, 0);

    // Long press from enable=1: long_pulse 16 edges after HELD, no press on release.
    short_press(10, 1'b1);
    btn_raw = 1'b0;
    expect_ev(1'b1, 1'b0, 23);
    tick(23);
    check("long_pulse", long_pulse, 1);
    check("long_enable", enable, 0);
    check("long_state", state, 2);
    tick(17);
    btn_raw = 1'b1;
    tick(6);
    check("long_still_held", state, 2);
    tick(1);
    check("long_released", state, 0);
    check("long_release_press", press_pulse, 0);
    tick(12);

    // Boundary: btn_db falls as hold_cnt reaches 15; release wins.
    btn_raw = 1'b0;
    tick(16);
    btn_raw = 1'b1;
    expect_ev(1'b0, 1'b1, 7);
    tick(6);
    check("bnd_hold_cnt", dut.hold_cnt_q, 15);
    check("bnd_db", dut.btn_db_q, 0);
    check("bnd_state", state, 1);
    tick(1);
    check("bnd_press", press_pulse, 1);
    check("bnd_long", long_pulse, 0);
    check("bnd_enable", enable, 1);
    tick(12);

    // Reset mid-press, then the still-held button must re-qualify.
    btn_raw = 1'b0;
    tick(10);
    check("mid_state_held", state, 1);
    rst = 1'b0;
    tick(3);
    check("mid_rst_enable", enable, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_press", press_pulse, 0);
    check("mid_rst_long", long_pulse, 0);
    check("mid_rst_db", dut.btn_db_q, 0);
    rst = 1'b1;
    tick(6);
    check("mid_db_requal", dut.btn_db_q, 1);
    check("mid_state_wait", state, 0);
    tick(1);
    check("mid_state_reheld", state, 1);
    btn_raw = 1'b1;
    expect_ev(1'b0, 1'b1, 7);
    tick(7);
    check("mid_enable", enable, 1);

    tick(20);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
